ef_modcounter: RTL and testbench

//   Parametrised enable/direction (E/F) modulo counter FSM, the N-bit successor of the 2-bit E/F counter.

---
 rtl/ef_modcounter.sv | 102 ++++++++++
 tb/tb_ef_modcounter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ef_modcounter.sv
// Enable/direction (E/F) modulo counter: counts 0..MODULUS-1 up or down, with
// parallel load, wrap-or-saturate ends, a combinational terminal count and a registered overflow pulse.
module ef_modcounter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             E,
    input  logic             F,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] present,
    output logic [WIDTH-1:0] next,
    output logic             tc,
    output logic             ovf
);

    generate
        if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
            $error("ef_modcounter: MODULUS must lie in 2..2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH:0] MAX_V  = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE_V  = (WIDTH + 1)'(1);
    localparam logic [WIDTH:0] ZERO_V = '0;

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_UP   = 3'd2;
    localparam logic [2:0] OP_DOWN = 3'd3;
    localparam logic [2:0] OP_BAD  = 3'd4;

    logic [WIDTH-1:0] present_q, present_d;
    logic             ovf_q, ovf_d;
    logic             tc_d;
    logic [2:0]       op;
    logic [WIDTH:0]   cur_ext, load_ext, next_ext;
    logic             unused_msb;

    always_comb begin
        cur_ext  = {1'b0, present_q};
        load_ext = {1'b0, load_val};
        tc_d     = 1'b0;
        next_ext = cur_ext;

        // An out-of-range state (only reachable by upset) overrides every input.
        if (cur_ext > MAX_V) begin
            op = OP_BAD;
        end else if (load) begin
            op = OP_LOAD;
        end else if (E) begin
            op = F ? OP_UP : OP_DOWN;
        end else begin
            op = OP_HOLD;
        end

        case (op)
            OP_HOLD: next_ext = cur_ext;
            OP_LOAD: next_ext = (load_ext > MAX_V) ? MAX_V : load_ext;
            OP_UP: begin
                if (cur_ext == MAX_V) begin
                    tc_d     = 1'b1;
                    next_ext = SATURATE ? MAX_V : ZERO_V;
                end else begin
                    next_ext = cur_ext + ONE_V;
                end
            end
            OP_DOWN: begin
                if (cur_ext == ZERO_V) begin
                    tc_d     = 1'b1;
                    next_ext = SATURATE ? ZERO_V : MAX_V;
                end else begin
                    next_ext = cur_ext - ONE_V;
                end
            end
            default: next_ext = ZERO_V;
        endcase

        present_d  = next_ext[WIDTH-1:0];
        unused_msb = next_ext[WIDTH];
        ovf_d      = tc_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            present_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            present_q <= present_d;
            ovf_q     <= ovf_d;
        end
    end

    assign present = present_q;
    assign next    = present_d;
    assign tc      = tc_d;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_ef_modcounter.sv
// Scoreboard bench for ef_modcounter: wrap (W4/M10), saturate (W4/M10) and legacy (W2/M4) instances
// share the stimulus; each transaction names the instance whose response is checked.
module tb_ef_modcounter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       E = 1'b0;
    logic       F = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;

    logic [3:0] present0, next0, present1, next1;
    logic [1:0] present2, next2;
    logic       tc0, tc1, tc2, ovf0, ovf1, ovf2;

    always #5 clk = ~clk;

    ef_modcounter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .E(E), .F(F), .load(load), .load_val(load_val),
        .present(present0), .next(next0), .tc(tc0), .ovf(ovf0)
    );

    ef_modcounter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .E(E), .F(F), .load(load), .load_val(load_val),
        .present(present1), .next(next1), .tc(tc1), .ovf(ovf1)
    );

    ef_modcounter #(.WIDTH(2), .MODULUS(4), .SATURATE(1'b0)) dut_legacy (
        .clk(clk), .reset(reset), .E(E), .F(F), .load(load), .load_val(load_val[1:0]),
        .present(present2), .next(next2), .tc(tc2), .ovf(ovf2)
    );

    typedef struct {
        int         dut;
        bit         chk_pre;
        logic [3:0] nx;
        logic       tc;
        logic [3:0] pr;
        logic       ov;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   n_pushed = 0;
    int   n_checked = 0;

    task automatic chk(input string name, input int dut, input logic [3:0] got, input logic [3:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s dut%0d: got %0d want %0d", name, dut, got, want);
        end
    endtask

    // One clock edge: drive inputs at the falling edge and queue the expected response.
    task automatic step(input int dut, input logic r, input logic e, input logic f, input logic ld,
                        input logic [3:0] lv, input bit chk_pre, input logic [3:0] nx, input logic t,
                        input logic [3:0] pr, input logic ov);
        exp_t x;
        @(negedge clk);
        reset = r; E = e; F = f; load = ld; load_val = lv;
        x.dut = dut; x.chk_pre = chk_pre; x.nx = nx; x.tc = t; x.pr = pr; x.ov = ov;
        exp_q.push_back(x);
        n_pushed++;
    endtask

    // Monitor: comb outputs sampled 1 time unit after the falling edge, state 1 unit after the rising edge.
    initial begin : monitor
        exp_t       x;
        logic [3:0] g_nx, g_pr;
        logic       g_tc, g_ov;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                case (x.dut)
                    0:       begin g_nx = next0; g_tc = tc0; end
                    1:       begin g_nx = next1; g_tc = tc1; end
                    default: begin g_nx = {2'b00, next2}; g_tc = tc2; end
                endcase
                @(posedge clk);
                #1;
                case (x.dut)
                    0:       begin g_pr = present0; g_ov = ovf0; end
                    1:       begin g_pr = present1; g_ov = ovf1; end
                    default: begin g_pr = {2'b00, present2}; g_ov = ovf2; end
                endcase
                if (x.chk_pre) begin
                    chk("next", x.dut, g_nx, x.nx);
                    chk("tc", x.dut, {3'b000, g_tc}, {3'b000, x.tc});
                end
                chk("present", x.dut, g_pr, x.pr);
                chk("ovf", x.dut, {3'b000, g_ov}, {3'b000, x.ov});
                $display("txn %0d dut%0d: next=%0d tc=%0d present=%0d ovf=%0d", n_checked, x.dut,
                         g_nx, g_tc, g_pr, g_ov);
                n_checked++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation timed out");
    end

    initial begin : stimulus
        int p;
        // 1. reset with E=1,F=1 for two edges; next already shows 1 on the second
        step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0);
        // 2. up wrap over 12 edges: 1..9,0,1,2; tc at 9, ovf on the following cycle
        for (int i = 0; i < 12; i++) begin
            p = i % 10;
            step(0, 0, 1, 1, 0, 0, 1, 4'((p + 1) % 10), (p == 9), 4'((p + 1) % 10), (p == 9));
        end
        // 3. back to 0, down wrap 9,8,7, then hold
        step(0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 1, 9, 1, 9, 1);
        step(0, 0, 1, 0, 0, 0, 1, 8, 0, 8, 0);
        step(0, 0, 1, 0, 0, 0, 1, 7, 0, 7, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1, 7, 0, 7, 0);
        // 5. load beats E, clamps, and loses to reset; load at MAX does not raise tc
        step(0, 0, 1, 1, 1, 5, 1, 5, 0, 5, 0);
        step(0, 0, 1, 1, 1, 15, 1, 9, 0, 9, 0);
        step(0, 1, 1, 1, 1, 3, 1, 3, 0, 0, 0);
        step(0, 0, 0, 0, 1, 9, 1, 9, 0, 9, 0);
        step(0, 0, 1, 1, 1, 9, 1, 9, 0, 9, 0);
        // 4. saturating instance: 8 -> 9, held at 9 with tc/ovf, then down to 8
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 8, 1, 8, 0, 8, 0);
        step(1, 0, 1, 1, 0, 0, 1, 9, 0, 9, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 0, 0, 1, 9, 1, 9, 1);
        step(1, 0, 1, 0, 0, 0, 1, 8, 0, 8, 0);
        step(1, 1, 0, 0, 0, 0, 1, 8, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1);
        step(1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1);
        // 6. legacy 2-bit counter: 0,1,2,3,0 then 3,2 then hold
        step(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(2, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0);
        step(2, 0, 1, 1, 0, 0, 1, 2, 0, 2, 0);
        step(2, 0, 1, 1, 0, 0, 1, 3, 0, 3, 0);
        step(2, 0, 1, 1, 0, 0, 1, 0, 1, 0, 1);
        step(2, 0, 1, 0, 0, 0, 1, 3, 1, 3, 1);
        step(2, 0, 1, 0, 0, 0, 1, 2, 0, 2, 0);
        step(2, 0, 0, 0, 0, 0, 1, 2, 0, 2, 0);
        step(2, 0, 0, 1, 0, 0, 1, 2, 0, 2, 0);

        @(negedge clk);
        E = 1'b0; load = 1'b0; reset = 1'b0;
        for (int i = 0; i < 20 && n_checked < n_pushed; i++) @(negedge clk);
        chk("drained", 0, 4'(n_checked % 16), 4'(n_pushed % 16));
        if (n_checked != n_pushed) begin
            bad++;
            $display("FAIL scoreboard: got %0d checked want %0d", n_checked, n_pushed);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
